wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the five-stage pipeline. It consumes the MEM/WB pipeline register outputs and formats load data (sign/zero extension, byte/halfword lane select). It selects the write-back source, commits the result to a 32×32 register file, and serves the ID stage's two read ports with same-cycle write-through. It also keeps cycle and retired-instruction counters for performance monitoring.

## Interface
- No parameters. XLEN fixed at 32, 32 registers.
- Encodings (shared defines):
  - DMRd: `DMRd_NOP`=4'b0000, LW=4'b0001, LH=4'b0010, LHU=4'b0011, LB=4'b0100, LBU=4'b0101. Other codes are treated as NOP.
  - toReg: `ALU2Reg`=2'b00, `Mem2Reg`=2'b01, `PC2Reg`=2'b10. 2'b11 is treated as ALU2Reg.
- Ports:
  - clk  in  1  clock, rising edge
  - rst  in  1  reset, synchronous, active-high
  - MEMWB_RFWr  in  1  register write enable
  - MEMWB_rd  in  5  destination register
  - MEMWB_ins  in  32  instruction word; 32'b0 = bubble
  - MEMWB_pc  in  32  instruction PC
  - MEMWB_DMRd  in  4  load type
  - MEMWB_toReg  in  2  write-back source select
  - MEMWB_DMout  in  32  aligned data-memory word
  - MEMWB_ALUout  in  32  ALU result / load address
  - rs1, rs2  in  5 each  ID read addresses
  - rdata1, rdata2  out  32 each  ID read data (combinational)
  - wb_data  out  32  selected write-back value (combinational, for EX forwarding)
  - wb_we  out  1  effective write strobe: MEMWB_RFWr && MEMWB_rd != 0
  - cycle_cnt  out  64  cycles since reset
  - instret_cnt  out  64  retired instructions since reset

## Operation
- Load formatting, with byte offset off = MEMWB_ALUout[1:0]:
  - LW: the word as-is; off is ignored.
  - LH/LHU: half = off[1] ? DMout[31:16] : DMout[15:0], then sign- or zero-extended. off[0] is ignored (no misalignment trap).
  - LB/LBU: byte lane off (0 = DMout[7:0] … 3 = DMout[31:24]), then sign- or zero-extended.
  - NOP/unknown: the word as-is.
- wb_data:
  - ALU2Reg: MEMWB_ALUout.
  - Mem2Reg: the formatted load value.
  - PC2Reg: MEMWB_pc + 4, computed mod 2^32 (0xFFFFFFFC → 0x00000000).
- Register file: 32 × 32 flops. On the rising edge, if wb_we, regs[MEMWB_rd] <= wb_data.
- x0: never written. Reads of x0 return 0 regardless of bypass.
- Read port n:
  - 0 if rsn == 0.
  - Else wb_data if wb_we && MEMWB_rd == rsn (write-through).
  - Else regs[rsn].
- cycle_cnt increments every non-reset cycle and wraps at 2^64 − 1 → 0.
- instret_cnt increments on an edge when MEMWB_ins != 0 (non-bubble). This is independent of RFWr, so stores and branches count. It wraps the same way.

## Timing
- Load formatting, wb_data and the read ports are combinational; zero latency from inputs.
- A register write commits at the rising edge ending the cycle in which wb_we is high. Readers see the value the same cycle via bypass and from the array thereafter.
- rst sampled high at an edge, with priority over everything:
  - all 32 registers <= 0
  - cycle_cnt <= 0, instret_cnt <= 0
  - any pending write that cycle is dropped
  - mid-operation reset behaves identically
- Values after reset: rdata1/rdata2 = 0 for any address with no concurrent write; wb_data follows its inputs; counters read 0 on the first cycle after reset deasserts.
- The first non-reset edge sets cycle_cnt = 1.
- rs1 == rs2 == MEMWB_rd: both ports receive the bypassed value.

## Test plan
- Reset: preload x5 = 0x12345678, assert rst one edge → rdata1(rs1 = 5) = 0, cycle_cnt = 0, instret_cnt = 0.
- Write/bypass:
  - RFWr = 1, rd = 7, ALU2Reg, ALUout = 0xDEADBEEF, rs1 = rs2 = 7 → both rdata = 0xDEADBEEF in the same cycle and after the edge.
  - rd = 0 → wb_we = 0, x0 reads 0.
- Loads with DMout = 0x80FF7F01:
  - LB off = 3 → 0xFFFFFF80; LBU off = 3 → 0x00000080
  - LB off = 1 → 0x0000007F
  - LH off = 2 → 0xFFFF80FF; LHU off = 0 → 0x00007F01
  - LW off = 2 → 0x80FF7F01
- PC2Reg: pc = 0x00000100 → wb_data = 0x00000104; pc = 0xFFFFFFFC → 0x00000000.
- Counters:
  - 10 cycles with 4 nonzero ins (one a store with RFWr = 0) and 6 bubbles → cycle_cnt = 10, instret_cnt = 4.
  - rst asserted with RFWr = 1 that edge → write dropped, counters 0.
- Randomized: 10k random writes/reads against a reference model; check every read, including bypass collisions and rd = 0.

Source files
------------

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//
// Write-back stage and architectural register file of the five-stage pipeline.
// Formats load data from the MEM/WB register and picks the write-back source.
// Commits the result into a 32 x 32 register file. Serves the two ID read ports
// with same-cycle write-through. Also keeps 64-bit cycle and retired-instruction
// counters.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst           in   1   synchronous, active-high reset
//   MEMWB_RFWr    in   1   register write enable
//   MEMWB_rd      in   5   destination register
//   MEMWB_ins     in  32   instruction word (32'b0 = bubble)
//   MEMWB_pc      in  32   instruction PC
//   MEMWB_DMRd    in   4   load type
//   MEMWB_toReg   in   2   write-back source select
//   MEMWB_DMout   in  32   aligned data-memory word
//   MEMWB_ALUout  in  32   ALU result / load address
//   rs1, rs2      in   5   ID read addresses
//   rdata1/2      out 32   ID read data (combinational, write-through)
//   wb_data       out 32   selected write-back value (for EX forwarding)
//   wb_we         out  1   effective write strobe (RFWr and rd != x0)
//   cycle_cnt     out 64   cycles since reset
//   instret_cnt   out 64   retired (non-bubble) instructions since reset
// -----------------------------------------------------------------------------
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEMWB_RFWr,
    input  logic [4:0]  MEMWB_rd,
    input  logic [31:0] MEMWB_ins,
    input  logic [31:0] MEMWB_pc,
    input  logic [3:0]  MEMWB_DMRd,
    input  logic [1:0]  MEMWB_toReg,
    input  logic [31:0] MEMWB_DMout,
    input  logic [31:0] MEMWB_ALUout,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] wb_data,
    output logic        wb_we,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    // Load-type encodings
    localparam logic [3:0] DMRD_NOP = 4'b0000;
    localparam logic [3:0] DMRD_LW  = 4'b0001;
    localparam logic [3:0] DMRD_LH  = 4'b0010;
    localparam logic [3:0] DMRD_LHU = 4'b0011;
    localparam logic [3:0] DMRD_LB  = 4'b0100;
    localparam logic [3:0] DMRD_LBU = 4'b0101;

    // Write-back source encodings (2'b11 falls back to the ALU result)
    localparam logic [1:0] ALU2REG = 2'b00;
    localparam logic [1:0] MEM2REG = 2'b01;
    localparam logic [1:0] PC2REG  = 2'b10;

    logic [31:0] regs [32];
    logic [31:0] load_data;
    logic [15:0] half;
    logic [7:0]  byte_sel;
    logic [1:0]  off;

    assign off = MEMWB_ALUout[1:0];

    // Lane selection. The halfword lane uses only off[1]. Misaligned halfwords
    // silently use the lower/upper half without trapping.
    assign half = off[1] ? MEMWB_DMout[31:16] : MEMWB_DMout[15:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        byte_sel = MEMWB_DMout[7:0];
        case (off)
            2'd0: byte_sel = MEMWB_DMout[7:0];
            2'd1: byte_sel = MEMWB_DMout[15:8];
            2'd2: byte_sel = MEMWB_DMout[23:16];
            2'd3: byte_sel = MEMWB_DMout[31:24];
            default: byte_sel = MEMWB_DMout[7:0];
        endcase
    end

    always_comb begin
        load_data = MEMWB_DMout;
        case (MEMWB_DMRd)
            DMRD_LW:  load_data = MEMWB_DMout;
            DMRD_LH:  load_data = {{16{half[15]}}, half};
            DMRD_LHU: load_data = {16'h0000, half};
            DMRD_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            DMRD_LBU: load_data = {24'h000000, byte_sel};
            DMRD_NOP: load_data = MEMWB_DMout;
            default:  load_data = MEMWB_DMout;
        endcase
    end

    always_comb begin
        wb_data = MEMWB_ALUout;
        case (MEMWB_toReg)
            ALU2REG: wb_data = MEMWB_ALUout;
            MEM2REG: wb_data = load_data;
            PC2REG:  wb_data = MEMWB_pc + 32'd4;   // wraps mod 2^32
            default: wb_data = MEMWB_ALUout;
        endcase
    end

    // x0 is hard-wired, so a write aimed at it is not a write at all.
    assign wb_we = MEMWB_RFWr && (MEMWB_rd != 5'd0);

    // Register array. Reset clears every entry, and a reset edge drops any
    // write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this array is small architectural state that must read 0
            // after reset, so it lives in flops with an explicit clear.
            // Do not map it to a RAM macro, which could not be reset this way.
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[MEMWB_rd] <= wb_data;
        end
    end

    // Read ports: x0 first, then write-through from the committing write,
    // then the array.
    always_comb begin
        rdata1 = regs[rs1];
        if (rs1 == 5'd0)
            rdata1 = '0;
        else if (wb_we && (MEMWB_rd == rs1))
            rdata1 = wb_data;
    end

    always_comb begin
        rdata2 = regs[rs2];
        if (rs2 == 5'd0)
            rdata2 = '0;
        else if (wb_we && (MEMWB_rd == rs2))
            rdata2 = wb_data;
    end

    // Performance counters. Both wrap naturally at 2^64.
    // An instruction retires when it is not a bubble, even without a register
    // write (stores and branches count).
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (MEMWB_ins != 32'd0)
                instret_cnt <= instret_cnt + 64'd1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//
// Directed, self-checking bench for wb_regfile. Inputs change on the falling
// edge. Combinational outputs are sampled 1 ns later. Registered state is
// observed on the falling edge after the rising edge that updates it.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        MEMWB_RFWr;
    logic [4:0]  MEMWB_rd;
    logic [31:0] MEMWB_ins;
    logic [31:0] MEMWB_pc;
    logic [3:0]  MEMWB_DMRd;
    logic [1:0]  MEMWB_toReg;
    logic [31:0] MEMWB_DMout;
    logic [31:0] MEMWB_ALUout;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .MEMWB_RFWr   (MEMWB_RFWr),
        .MEMWB_rd     (MEMWB_rd),
        .MEMWB_ins    (MEMWB_ins),
        .MEMWB_pc     (MEMWB_pc),
        .MEMWB_DMRd   (MEMWB_DMRd),
        .MEMWB_toReg  (MEMWB_toReg),
        .MEMWB_DMout  (MEMWB_DMout),
        .MEMWB_ALUout (MEMWB_ALUout),
        .rs1          (rs1),
        .rs2          (rs2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .wb_data      (wb_data),
        .wb_we        (wb_we),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        MEMWB_RFWr   = 1'b0;
        MEMWB_rd     = 5'd0;
        MEMWB_ins    = 32'd0;
        MEMWB_pc     = 32'd0;
        MEMWB_DMRd   = 4'b0000;
        MEMWB_toReg  = 2'b00;
        MEMWB_DMout  = 32'd0;
        MEMWB_ALUout = 32'd0;
        rs1          = 5'd0;
        rs2          = 5'd0;
    endtask

    // Present an ALU write on the falling edge. It commits at the next rising edge.
    task automatic alu_write(input logic [4:0] rd, input logic [31:0] val);
        @(negedge clk);
        idle_inputs();
        MEMWB_RFWr   = 1'b1;
        MEMWB_rd     = rd;
        MEMWB_ALUout = val;
        @(posedge clk);
    endtask

    task automatic test_reset();
        alu_write(5'd5, 32'h1234_5678);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rs1 = 5'd5;
        #1;
        checks++;
        if (rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_x5: got %h expected %h", rdata1, 32'd0);
        end
        checks++;
        if (cycle_cnt !== 64'd0) begin
            errors++;
            $display("FAIL reset_cycle: got %0d expected 0", cycle_cnt);
        end
        checks++;
        if (instret_cnt !== 64'd0) begin
            errors++;
            $display("FAIL reset_instret: got %0d expected 0", instret_cnt);
        end
    endtask

    task automatic test_write_bypass();
        @(negedge clk);
        idle_inputs();
        MEMWB_RFWr   = 1'b1;
        MEMWB_rd     = 5'd7;
        MEMWB_toReg  = 2'b00;
        MEMWB_ALUout = 32'hDEAD_BEEF;
        rs1 = 5'd7;
        rs2 = 5'd7;
        #1;
        checks++;
        if (rdata1 !== 32'hDEAD_BEEF || rdata2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h/%h expected deadbeef", rdata1, rdata2);
        end
        @(posedge clk);
        @(negedge clk);
        MEMWB_RFWr   = 1'b0;
        MEMWB_ALUout = 32'h0;
        #1;
        checks++;
        if (rdata1 !== 32'hDEAD_BEEF || rdata2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL array_after_edge: got %h/%h expected deadbeef", rdata1, rdata2);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        idle_inputs();
        MEMWB_RFWr   = 1'b1;
        MEMWB_rd     = 5'd0;
        MEMWB_ALUout = 32'hCAFE_F00D;
        rs1 = 5'd0;
        rs2 = 5'd0;
        #1;
        checks++;
        if (wb_we !== 1'b0) begin
            errors++;
            $display("FAIL x0_we: got %b expected 0", wb_we);
        end
        checks++;
        if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
            errors++;
            $display("FAIL x0_bypass: got %h/%h expected 0", rdata1, rdata2);
        end
        @(posedge clk);
        @(negedge clk);
        MEMWB_RFWr = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL x0_after_edge: got %h expected 0", rdata1);
        end
    endtask

    task automatic test_loads();
        logic [3:0]  dmrd [7];
        logic [1:0]  offs [7];
        logic [31:0] exp  [7];
        dmrd[0] = 4'b0100; offs[0] = 2'd3; exp[0] = 32'hFFFF_FF80; // LB
        dmrd[1] = 4'b0101; offs[1] = 2'd3; exp[1] = 32'h0000_0080; // LBU
        dmrd[2] = 4'b0100; offs[2] = 2'd1; exp[2] = 32'h0000_007F; // LB
        dmrd[3] = 4'b0010; offs[3] = 2'd2; exp[3] = 32'hFFFF_80FF; // LH
        dmrd[4] = 4'b0011; offs[4] = 2'd0; exp[4] = 32'h0000_7F01; // LHU
        dmrd[5] = 4'b0001; offs[5] = 2'd2; exp[5] = 32'h80FF_7F01; // LW
        dmrd[6] = 4'b0111; offs[6] = 2'd1; exp[6] = 32'h80FF_7F01; // unknown
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            idle_inputs();
            MEMWB_toReg  = 2'b01;
            MEMWB_DMout  = 32'h80FF_7F01;
            MEMWB_DMRd   = dmrd[i];
            MEMWB_ALUout = {30'h1000_0000, offs[i]};
            #1;
            checks++;
            if (wb_data !== exp[i]) begin
                errors++;
                $display("FAIL load_%0d (DMRd=%b off=%0d): got %h expected %h",
                         i, dmrd[i], offs[i], wb_data, exp[i]);
            end
        end
    endtask

    task automatic test_pc2reg();
        logic [31:0] pcs [2];
        logic [31:0] exp [2];
        pcs[0] = 32'h0000_0100; exp[0] = 32'h0000_0104;
        pcs[1] = 32'hFFFF_FFFC; exp[1] = 32'h0000_0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle_inputs();
            MEMWB_toReg  = 2'b10;
            MEMWB_pc     = pcs[i];
            MEMWB_ALUout = 32'h5555_5555;
            #1;
            checks++;
            if (wb_data !== exp[i]) begin
                errors++;
                $display("FAIL pc2reg_%0d: got %h expected %h", i, wb_data, exp[i]);
            end
        end
        @(negedge clk);
        idle_inputs();
        MEMWB_toReg  = 2'b11;
        MEMWB_ALUout = 32'h1357_9BDF;
        #1;
        checks++;
        if (wb_data !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL toreg_11: got %h expected 13579bdf", wb_data);
        end
    endtask

    task automatic test_counters();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            idle_inputs();
            case (i)
                1: begin MEMWB_ins = 32'h0000_0013; MEMWB_RFWr = 1'b1; MEMWB_rd = 5'd3; end
                4: begin MEMWB_ins = 32'h0020_A023; end   // store, no RFWr
                6: begin MEMWB_ins = 32'h0010_0093; MEMWB_RFWr = 1'b1; MEMWB_rd = 5'd1; end
                9: begin MEMWB_ins = 32'h0000_0063; end   // branch
                default: MEMWB_ins = 32'd0;
            endcase
            @(posedge clk);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (cycle_cnt !== 64'd10) begin
            errors++;
            $display("FAIL cnt_cycle: got %0d expected 10", cycle_cnt);
        end
        checks++;
        if (instret_cnt !== 64'd4) begin
            errors++;
            $display("FAIL cnt_instret: got %0d expected 4", instret_cnt);
        end
    endtask

    task automatic test_reset_drop();
        @(negedge clk);
        idle_inputs();
        rst          = 1'b1;
        MEMWB_RFWr   = 1'b1;
        MEMWB_rd     = 5'd9;
        MEMWB_ALUout = 32'hAAAA_5555;
        MEMWB_ins    = 32'h0000_0013;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        rs1 = 5'd9;
        #1;
        checks++;
        if (rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL rst_drop_write: got %h expected 0", rdata1);
        end
        checks++;
        if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
            errors++;
            $display("FAIL rst_drop_cnt: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (cycle_cnt !== 64'd1) begin
            errors++;
            $display("FAIL first_edge_cycle: got %0d expected 1", cycle_cnt);
        end
    endtask

    // Random writes and reads against a reference array. Registers start at 0
    // because the previous test ended with a reset.
    task automatic test_random();
        logic [31:0] model [32];
        logic [31:0] exp1;
        logic [31:0] exp2;
        bit          we;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            idle_inputs();
            MEMWB_RFWr   = 1'($urandom_range(0, 1));
            MEMWB_rd     = 5'($urandom_range(0, 31));
            MEMWB_ALUout = $urandom;
            rs1 = ($urandom_range(0, 3) == 0) ? MEMWB_rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? MEMWB_rd : 5'($urandom_range(0, 31));
            we   = MEMWB_RFWr && (MEMWB_rd != 5'd0);
            exp1 = (rs1 == 5'd0) ? 32'd0 : (we && MEMWB_rd == rs1) ? MEMWB_ALUout : model[rs1];
            exp2 = (rs2 == 5'd0) ? 32'd0 : (we && MEMWB_rd == rs2) ? MEMWB_ALUout : model[rs2];
            #1;
            checks++;
            if (rdata1 !== exp1) begin
                errors++;
                $display("FAIL rand_rd1 #%0d rs1=%0d: got %h expected %h", n, rs1, rdata1, exp1);
            end
            checks++;
            if (rdata2 !== exp2) begin
                errors++;
                $display("FAIL rand_rd2 #%0d rs2=%0d: got %h expected %h", n, rs2, rdata2, exp2);
            end
            @(posedge clk);
            if (we) model[MEMWB_rd] = MEMWB_ALUout;
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_write_bypass();
        test_x0();
        test_loads();
        test_pc2reg();
        test_counters();
        test_reset_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
